// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with 2-entry skid buffer, flush/req kill and perf counters
module pipe_stage_skid #(
    parameter int                DATA_W   = 256,
    parameter int                PC_W     = 32,
    parameter logic [PC_W-1:0]   EXC_VEC  = 32'h0000_4180,
    parameter logic [PC_W-1:0]   FLUSH_PC = 32'h0000_0000,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q;
    logic [PC_W-1:0]     skid_pc;
    logic [DATA_W-1:0]   skid_data;

    logic                in_fire;
    logic                out_fire;
    logic                kill;
    logic                stall_hit;
    logic [1:0]          drop_amt;
    logic [CNT_W:0]      drop_sum;
    logic [CNT_W-1:0]    drop_sat;
    logic [CNT_W-1:0]    stall_sat;

    // Handshake flags come only from registered state, so no comb path out_ready/flush/req -> in_ready
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);

    // Transfer qualifiers and saturating counter increments
    always_comb begin
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        kill      = req || flush;
        stall_hit = out_valid && !out_ready;
        drop_amt  = 2'd0;
        case (state_q)
            ONE:     drop_amt = 2'd1;
            FULL:    drop_amt = 2'd2;
            default: drop_amt = 2'd0;
        endcase
        drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(drop_amt);
        drop_sat  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        stall_sat = (&stall_cnt) ? stall_cnt : stall_cnt + 1'b1;
    end

    // Occupancy state machine with main (output) and skid registers; req beats flush beats transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            out_pc    <= '0;
            out_data  <= '0;
            skid_pc   <= '0;
            skid_data <= '0;
        end else if (kill) begin
            // Upstream is killed in the same cycle, so an in_fire here is simply dropped
            state_q   <= EMPTY;
            out_pc    <= req ? EXC_VEC : FLUSH_PC;
            out_data  <= '0;
            skid_pc   <= '0;
            skid_data <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q  <= ONE;
                        out_pc   <= in_pc;
                        out_data <= in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_pc   <= in_pc;
                        out_data <= in_data;
                    end else if (out_fire) begin
                        // Keep last payload visible; out_valid drop marks it stale
                        state_q <= EMPTY;
                    end else if (in_fire) begin
                        state_q   <= FULL;
                        skid_pc   <= in_pc;
                        skid_data <= in_data;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_q  <= ONE;
                        out_pc   <= skid_pc;
                        out_data <= skid_data;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Saturating perf counters; stalls are sampled before any kill on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (stall_hit) begin
                stall_cnt <= stall_sat;
            end
            if (kill) begin
                drop_cnt <= drop_sat;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid against a queue-based reference model
module tb_pipe_stage_skid;

    localparam int DATA_W = 256;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 16;
    localparam int GW     = 1 + 1 + PC_W + DATA_W + CNT_W + CNT_W + 1 + PC_W + 2 + 2;

    typedef logic [PC_W+DATA_W-1:0] ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              req;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [PC_W-1:0]   s_out_pc;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_stall;
    logic [1:0]        s_drop;

    logic [GW-1:0]     got;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    ent_t              q[$];
    logic [PC_W-1:0]   shown_pc;
    logic [DATA_W-1:0] shown_data;
    int                stall_raw;
    int                drop_raw;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .flush(flush), .req(req),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    pipe_stage_skid #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_data(in_data),
        .flush(flush), .req(req),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_data(s_out_data),
        .stall_cnt(s_stall), .drop_cnt(s_drop)
    );

    assign got = {out_valid, in_ready, out_pc, out_data, stall_cnt, drop_cnt,
                  s_out_valid, s_out_pc, s_stall, s_drop};

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [GW-1:0] expect_now();
        logic             v;
        logic             r;
        logic [CNT_W-1:0] st;
        logic [CNT_W-1:0] dr;
        logic [1:0]       st2;
        logic [1:0]       dr2;
        v   = (q.size() > 0);
        r   = (q.size() < 2);
        st  = (stall_raw > 65535) ? 16'hFFFF : CNT_W'(stall_raw);
        dr  = (drop_raw > 65535) ? 16'hFFFF : CNT_W'(drop_raw);
        st2 = (stall_raw > 3) ? 2'd3 : 2'(stall_raw);
        dr2 = (drop_raw > 3) ? 2'd3 : 2'(drop_raw);
        return {v, r, shown_pc, shown_data, st, dr, v, shown_pc, st2, dr2};
    endfunction

    task automatic model_reset();
        q.delete();
        shown_pc   = '0;
        shown_data = '0;
        stall_raw  = 0;
        drop_raw   = 0;
    endtask

    // advance the model by one edge using current inputs, then clock the DUT
    task automatic step();
        int   n;
        bit   of;
        bit   inf;
        ent_t e;
        n = q.size();
        if (n > 0 && !out_ready) stall_raw++;
        if (req || flush) begin
            drop_raw  += n;
            q.delete();
            shown_pc   = req ? 32'h0000_4180 : 32'h0000_0000;
            shown_data = '0;
        end else begin
            of  = (n > 0) && out_ready;
            inf = in_valid && (n < 2);
            if (of) e = q.pop_front();
            if (inf) q.push_back({in_pc, in_data});
            if (q.size() > 0) {shown_pc, shown_data} = q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
        flush = 1'b0; req = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", got, expect_now());
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_pc = 32'h3000; in_data = rand_data(); out_ready = 1'b1;
        step();
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL single_load: got %h expected %h", got, expect_now());
        end
        vectors++;
        if ({out_valid, in_ready, out_pc} !== {1'b1, 1'b1, 32'h3000}) begin
            miscompares++;
            $display("FAIL single_latency: got v=%0b r=%0b pc=%h expected v=1 r=1 pc=00003000",
                     out_valid, in_ready, out_pc);
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL single_drain: got %h expected %h", got, expect_now());
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = 32'h3000 + 32'(4*i); in_data = rand_data();
            step();
            vectors++;
            if (got !== expect_now()) begin
                miscompares++;
                $display("FAIL stream_%0d: got %h expected %h", i, got, expect_now());
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL stream_drain: got %h expected %h", got, expect_now());
        end
    endtask

    task automatic test_backpressure();
        int k;
        bit fire;
        k = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) out_ready = 1'b1;
            in_valid = (k < 3);
            in_pc    = 32'h3000 + 32'(4*k);
            if (c == 0 || fire) in_data = rand_data();
            fire = in_valid && in_ready;
            step();
            if (fire) k++;
            vectors++;
            if (got !== expect_now()) begin
                miscompares++;
                $display("FAIL backpressure_c%0d: got %h expected %h", c, got, expect_now());
            end
            if (c == 3) begin
                vectors++;
                if ({in_ready, out_pc} !== {1'b0, 32'h3000}) begin
                    miscompares++;
                    $display("FAIL backpressure_full: got r=%0b pc=%h expected r=0 pc=00003000",
                             in_ready, out_pc);
                end
            end
        end
    endtask

    task automatic test_req_full();
        logic [CNT_W-1:0] prev_drop;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_pc = 32'h3100 + 32'(4*i); in_data = rand_data();
            step();
        end
        prev_drop = drop_cnt;
        req = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3200; in_data = rand_data();
        step();
        req = 1'b0; flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL req_full: got %h expected %h", got, expect_now());
        end
        vectors++;
        if ({out_valid, in_ready, out_pc, out_data, drop_cnt} !==
            {1'b0, 1'b1, 32'h0000_4180, {DATA_W{1'b0}}, CNT_W'(prev_drop + 2)}) begin
            miscompares++;
            $display("FAIL req_vector: got v=%0b r=%0b pc=%h drop=%0d expected v=0 r=1 pc=00004180 drop=%0d",
                     out_valid, in_ready, out_pc, drop_cnt, prev_drop + 2);
        end
    endtask

    task automatic test_flush_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h3300; in_data = rand_data();
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (got !== expect_now()) begin
                miscompares++;
                $display("FAIL stall_%0d: got %h expected %h", i, got, expect_now());
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL flush_one: got %h expected %h", got, expect_now());
        end
        vectors++;
        if ({out_valid, out_pc, s_stall} !== {1'b0, 32'h0, 2'd3}) begin
            miscompares++;
            $display("FAIL flush_sat: got v=%0b pc=%h small_stall=%0d expected v=0 pc=00000000 small_stall=3",
                     out_valid, out_pc, s_stall);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            req       = ($urandom_range(31) == 0);
            flush     = ($urandom_range(15) == 0);
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_data   = rand_data();
            step();
            vectors++;
            if (got !== expect_now()) begin
                miscompares++;
                $display("FAIL random_c%0d: got %h expected %h", c, got, expect_now());
            end
        end
        req = 1'b0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h3400; in_data = rand_data();
        step();
        in_pc = 32'h3404; in_data = rand_data();
        step();
        #1 reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", got, expect_now());
        end
        #1 reset = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h5000; in_data = rand_data();
        step();
        in_valid = 1'b0;
        vectors++;
        if (got !== expect_now()) begin
            miscompares++;
            $display("FAIL post_reset_load: got %h expected %h", got, expect_now());
        end
        vectors++;
        if ({out_valid, out_pc} !== {1'b1, 32'h5000}) begin
            miscompares++;
            $display("FAIL post_reset_pc: got v=%0b pc=%h expected v=1 pc=00005000", out_valid, out_pc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_req_full();
        test_flush_stall();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
